// File: rtl/sp_ram_dual_be.sv
// Byte-enabled single-clock RAM with one write and one read port, self-clearing INIT sequence.
// Optional macro SP_RAM_OUT_REG_EN adds an output register stage (read/error latency 2 instead of 1).
module sp_ram_dual_be #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr_req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              init_done,
    output logic              acc_err
);

    localparam int NB    = WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W:0]     cnt_r;
    logic [ADDR_W:0]     cnt_nxt_s;
    logic                init_done_r;

    logic [WIDTH-1:0]    mem_r [DEPTH];

    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [NB-1:0]       mem_wmask_s;
    logic [WIDTH-1:0]    mem_wdata_s;

    logic                rd_acc_s;
    logic                drop_s;
    logic [NB-1:0]       hit_be_s;
    logic [WIDTH-1:0]    rd_merge_s;

    logic [WIDTH-1:0]    rd_data_r;
    logic                rd_valid_r;
    logic                acc_err_r;

    // Replace the bytes of old_w selected by be with the matching bytes of new_w.
    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [NB-1:0]    be
    );
        logic [WIDTH-1:0] res;
        res = old_w;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Next-state and clear-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_INIT: begin
                cnt_nxt_s = cnt_r + {{ADDR_W{1'b0}}, 1'b1};
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_nxt_s = ST_INIT;
                    cnt_nxt_s   = {(ADDR_W + 1){1'b0}};
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
                cnt_nxt_s   = {(ADDR_W + 1){1'b0}};
            end
        endcase
    end

    // State, counter and init_done registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_INIT;
            cnt_r       <= {(ADDR_W + 1){1'b0}};
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            init_done_r <= (state_nxt_s == ST_READY);
        end
    end

    // Memory write port mux: clearing sweep in INIT, user writes in READY; idle while reset is held.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = {ADDR_W{1'b0}};
        mem_wmask_s = {NB{1'b0}};
        mem_wdata_s = {WIDTH{1'b0}};
        case (state_r)
            ST_INIT: begin
                mem_we_s    = rstn;
                mem_waddr_s = cnt_r[ADDR_W-1:0];
                mem_wmask_s = {NB{1'b1}};
            end
            ST_READY: begin
                if (wr_en) begin
                    mem_we_s    = rstn;
                    mem_waddr_s = wr_addr;
                    mem_wmask_s = wr_be;
                    mem_wdata_s = wr_data;
                end else begin
                    mem_we_s    = 1'b0;
                end
            end
            default: begin
                mem_we_s    = 1'b0;
            end
        endcase
    end

    // Storage array; no reset, contents are only cleared by the INIT sweep.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= merge_bytes(mem_r[mem_waddr_s], mem_wdata_s, mem_wmask_s);
        end
    end

    // Read acceptance, dropped-request detection and same-address write-through bypass.
    always_comb begin
        rd_acc_s = (state_r == ST_READY) && rd_en;
        drop_s   = (state_r == ST_INIT) && (wr_en || rd_en);
        if (wr_en && (wr_addr == rd_addr)) begin
            hit_be_s = wr_be;
        end else begin
            hit_be_s = {NB{1'b0}};
        end
        rd_merge_s = merge_bytes(mem_r[rd_addr], wr_data, hit_be_s);
    end

    // First read/error stage; rd_data holds between accepted reads.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_r  <= {WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
            acc_err_r  <= 1'b0;
        end else begin
            rd_valid_r <= rd_acc_s;
            acc_err_r  <= drop_s;
            if (rd_acc_s) begin
                rd_data_r <= rd_merge_s;
            end
        end
    end

`ifdef SP_RAM_OUT_REG_EN
    logic [WIDTH-1:0] rd_data_q_r;
    logic             rd_valid_q_r;
    logic             acc_err_q_r;

    // Extra output stage; bypass was already resolved in the first stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q_r  <= {WIDTH{1'b0}};
            rd_valid_q_r <= 1'b0;
            acc_err_q_r  <= 1'b0;
        end else begin
            rd_data_q_r  <= rd_data_r;
            rd_valid_q_r <= rd_valid_r;
            acc_err_q_r  <= acc_err_r;
        end
    end

    assign rd_data  = rd_data_q_r;
    assign rd_valid = rd_valid_q_r;
    assign acc_err  = acc_err_q_r;
`else
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign acc_err  = acc_err_r;
`endif

    assign init_done = init_done_r;

endmodule
